// File: rtl/bcd_field_editor.sv
// Push-button editor for NFIELD packed two-digit BCD fields with min/max limits and an AM/PM flag.
// Hold-to-repeat stepping is compiled in when BCD_EDITOR_AUTOREPEAT_EN is defined.
module bcd_field_editor #(
    parameter int unsigned NFIELD     = 3,
    parameter int unsigned REP_DELAY  = 25_000_000,
    parameter int unsigned REP_PERIOD = 5_000_000,
    localparam int unsigned CW = (NFIELD > 1) ? $clog2(NFIELD) : 1,
    localparam int unsigned VW = 8 * NFIELD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [VW-1:0] load_val,
    input  logic          load_flag,
    input  logic [VW-1:0] fmin,
    input  logic [VW-1:0] fmax,
    input  logic          flag_wrap_en,
    input  logic          bt_up,
    input  logic          bt_down,
    input  logic          bt_left,
    input  logic          bt_right,
    output logic [VW-1:0] val,
    output logic          flag,
    output logic [CW-1:0] cursor,
    output logic          changed
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EDIT = 2'd2
    } state_t;

    if ((NFIELD < 1) || (NFIELD > 8) || (REP_DELAY < 1) || (REP_PERIOD < 1)) begin : g_bad_cfg
        $error("bcd_field_editor: unsupported parameter set");
    end

    state_t        state_q, state_d;
    logic [VW-1:0] val_q, val_d;
    logic          flag_q, flag_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic          changed_q, changed_d;
    logic [3:0]    btn_prev_q, btn_prev_d;

    logic       rise_up, rise_dn, rise_l, rise_r;
    logic       edit_active, move_r, move_l;
    logic       step_up, step_dn;
    logic [7:0] cur_val, cur_min, cur_max;
    logic [7:0] inc_val, dec_val, new_fld;
    logic       bad_fld, wrapped;

    // Button edge detection and session decode
    always_comb begin
        btn_prev_d  = {bt_up, bt_down, bt_left, bt_right};
        rise_up     = bt_up    && !btn_prev_q[3];
        rise_dn     = bt_down  && !btn_prev_q[2];
        rise_l      = bt_left  && !btn_prev_q[1];
        rise_r      = bt_right && !btn_prev_q[0];
        edit_active = (state_q == S_EDIT) && en;
        move_r      = edit_active && rise_r && !rise_l;
        move_l      = edit_active && rise_l && !rise_r;
    end

`ifdef BCD_EDITOR_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned RW      = $clog2(REP_MAX + 1);

    // rep_cnt_q == 0 means disarmed: only a fresh press arms the repeat timer
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_phase_q, rep_phase_d;
    logic          held_one, rep_fire;

    always_comb begin
        held_one    = bt_up ^ bt_down;
        rep_fire    = edit_active && held_one && !rise_up && !rise_dn && (rep_cnt_q != '0) &&
                      (rep_cnt_q == (rep_phase_q ? RW'(REP_PERIOD) : RW'(REP_DELAY)));
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        if (!edit_active || !held_one || move_r || move_l) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (rise_up || rise_dn) begin
            rep_cnt_d   = RW'(1);
            rep_phase_d = 1'b0;
        end else if (rep_fire) begin
            rep_cnt_d   = RW'(1);
            rep_phase_d = 1'b1;
        end else if (rep_cnt_q != '0) begin
            rep_cnt_d   = rep_cnt_q + RW'(1);
        end
        step_up = edit_active && ((rise_up && !rise_dn) || (rep_fire && bt_up));
        step_dn = edit_active && ((rise_dn && !rise_up) || (rep_fire && bt_down));
    end
`else
    always_comb begin
        step_up = edit_active && rise_up && !rise_dn;
        step_dn = edit_active && rise_dn && !rise_up;
    end
`endif

    // Selected field and its limits
    always_comb begin
        cur_val = '0;
        cur_min = '0;
        cur_max = '0;
        for (int unsigned i = 0; i < NFIELD; i++) begin
            if (cursor_q == CW'(i)) begin
                cur_val = val_q[8*(NFIELD-1-i) +: 8];
                cur_min = fmin[8*(NFIELD-1-i) +: 8];
                cur_max = fmax[8*(NFIELD-1-i) +: 8];
            end
        end
    end

    // BCD step of the selected field, with limit wrap and invalid-value correction
    always_comb begin
        bad_fld = (cur_val[7:4] > 4'd9) || (cur_val[3:0] > 4'd9) ||
                  (cur_val < cur_min) || (cur_val > cur_max);
        inc_val = (cur_val[3:0] == 4'd9) ? {cur_val[7:4] + 4'd1, 4'd0}
                                         : {cur_val[7:4], cur_val[3:0] + 4'd1};
        dec_val = (cur_val[3:0] == 4'd0) ? {cur_val[7:4] - 4'd1, 4'd9}
                                         : {cur_val[7:4], cur_val[3:0] - 4'd1};
        new_fld = cur_val;
        wrapped = 1'b0;
        if (bad_fld) begin
            new_fld = cur_min;
        end else if (step_up) begin
            if (cur_val == cur_max) begin
                new_fld = cur_min;
                wrapped = 1'b1;
            end else begin
                new_fld = inc_val;
            end
        end else if (cur_val == cur_min) begin
            new_fld = cur_max;
            wrapped = 1'b1;
        end else begin
            new_fld = dec_val;
        end
    end

    // Session FSM and edit actions
    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        flag_d    = flag_q;
        cursor_d  = cursor_q;
        changed_d = 1'b0;
        if (!en) begin
            state_d  = S_IDLE;
            cursor_d = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_LOAD;
                S_LOAD: begin
                    val_d    = load_val;
                    flag_d   = load_flag;
                    cursor_d = '0;
                    state_d  = S_EDIT;
                end
                S_EDIT: begin
                    if (step_up || step_dn) begin
                        for (int unsigned i = 0; i < NFIELD; i++) begin
                            if (cursor_q == CW'(i)) begin
                                val_d[8*(NFIELD-1-i) +: 8] = new_fld;
                            end
                        end
                        if (wrapped && flag_wrap_en && (cursor_q == '0)) begin
                            flag_d = !flag_q;
                        end
                        changed_d = 1'b1;
                    end
                    if (move_r) begin
                        cursor_d = (cursor_q == CW'(NFIELD - 1)) ? '0 : cursor_q + CW'(1);
                    end else if (move_l) begin
                        cursor_d = (cursor_q == '0) ? CW'(NFIELD - 1) : cursor_q - CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            val_q       <= '0;
            flag_q      <= 1'b0;
            cursor_q    <= '0;
            changed_q   <= 1'b0;
            btn_prev_q  <= '0;
`ifdef BCD_EDITOR_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            flag_q      <= flag_d;
            cursor_q    <= cursor_d;
            changed_q   <= changed_d;
            btn_prev_q  <= btn_prev_d;
`ifdef BCD_EDITOR_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
`endif
        end
    end

    assign val     = val_q;
    assign flag    = flag_q;
    assign cursor  = cursor_q;
    assign changed = changed_q;

endmodule
